// File: rtl/shop_user_db_if.sv
// Token/response bus between the shop command source and shop_user_db.
// The master drives tokens; the slave (the user database) answers with status words.
interface shop_user_db_if #(
    parameter int I_A_NUM_ASCII_CHARS = 7,
    parameter int O_A_NUM_ASCII_CHARS = 9,
    parameter int I_U_NUM_BITS        = 4
);
    logic                             i_rdy;
    logic [I_A_NUM_ASCII_CHARS*8-1:0] i_a;
    logic [I_U_NUM_BITS-1:0]          i_u;
    logic [O_A_NUM_ASCII_CHARS*8-1:0] o_a;
    logic                             o_vld;

    modport master (
        output i_rdy, i_a, i_u,
        input  o_a, o_vld
    );

    modport slave (
        input  i_rdy, i_a, i_u,
        output o_a, o_vld
    );
endinterface

// File: rtl/shop_user_db.sv
// Command-driven user table, admin account and login session for the shop database.
// Optional per-user bad-password lockout is enabled with `define SHOP_LOCKOUT_EN.
//
// state      | meaning
// S_CMD      | waiting for a command token
// S_USERNAME | waiting for the username of the latched command
// S_PASSWORD | waiting for the password (login check or new-user password)
// S_PERMS    | waiting for the new user's permission code on i_u
module shop_user_db #(
    parameter int I_A_NUM_ASCII_CHARS = 7,
    parameter int O_A_NUM_ASCII_CHARS = 9,
    parameter int I_U_NUM_BITS        = 4,
    parameter int MAX_USERS           = 8,
    parameter int SLOT_BITS           = 4,
    parameter logic [I_A_NUM_ASCII_CHARS*8-1:0] ADMIN_USERNAME = "Adm",
    parameter logic [I_A_NUM_ASCII_CHARS*8-1:0] ADMIN_PASSWORD = "AdmPass",
    parameter int MAX_FAILS           = 3
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    shop_user_db_if.slave           bus,
    output logic                    o_logged_in,
    output logic [SLOT_BITS-1:0]    o_cur_slot,
    output logic [I_U_NUM_BITS-1:0] o_cur_perms
);
    localparam int IW = I_A_NUM_ASCII_CHARS * 8;
    localparam int OW = O_A_NUM_ASCII_CHARS * 8;

    localparam logic [IW-1:0] K_LOGIN  = "Login";
    localparam logic [IW-1:0] K_ADDUSR = "AddUsr";
    localparam logic [IW-1:0] K_DELUSR = "DelUsr";
    localparam logic [IW-1:0] K_LOGOUT = "Logout";

    localparam logic [OW-1:0] M_CMD      = "Cmd?";
    localparam logic [OW-1:0] M_INVCMD   = "InvalCmd";
    localparam logic [OW-1:0] M_INVPERM  = "InvalPerm";
    localparam logic [OW-1:0] M_FULL     = "UsrsFull";
    localparam logic [OW-1:0] M_LOGOUT   = "LoggedOut";
    localparam logic [OW-1:0] M_NOSESS   = "NoSession";
    localparam logic [OW-1:0] M_USRNAME  = "Usrname?";
    localparam logic [OW-1:0] M_PASSWD   = "Passwd?";
    localparam logic [OW-1:0] M_UNKNOWN  = "UsrUnknwn";
    localparam logic [OW-1:0] M_TAKEN    = "UsrTaken";
    localparam logic [OW-1:0] M_NODELADM = "NoDelAdmn";
    localparam logic [OW-1:0] M_DELETED  = "UsrDeletd";
    localparam logic [OW-1:0] M_LOGGEDIN = "LoggedIn";
    localparam logic [OW-1:0] M_BADPASS  = "BadPass";
    localparam logic [OW-1:0] M_PERMS    = "Perms?";
    localparam logic [OW-1:0] M_ADDED    = "UsrAdded";
`ifdef SHOP_LOCKOUT_EN
    localparam logic [OW-1:0] M_LOCKED   = "UsrLocked";
`endif

    if (MAX_USERS < 2 || MAX_USERS > 16 || (2**SLOT_BITS) < MAX_USERS || MAX_FAILS < 1) begin : g_param_check
        $error("shop_user_db: illegal parameter combination");
    end

    typedef enum logic [1:0] {S_CMD, S_USERNAME, S_PASSWORD, S_PERMS} state_t;
    typedef enum logic [1:0] {C_LOGIN, C_ADD, C_DEL} cmd_t;

    state_t r_state, w_state_nxt;
    cmd_t   r_cmd, w_cmd_nxt;

    logic [IW-1:0]           r_name [MAX_USERS];
    logic [IW-1:0]           r_pass [MAX_USERS];
    logic [I_U_NUM_BITS-1:0] r_perm [MAX_USERS];
    logic [MAX_USERS-1:0]    r_occ;

    logic [SLOT_BITS-1:0] r_tgt, w_tgt_nxt;
    logic [IW-1:0]        r_new_name, r_new_pass;
    logic [OW-1:0]        r_msg, w_msg;
    logic                 r_vld;
    logic                 r_logged_in;
    logic [SLOT_BITS-1:0] r_cur_slot;

    logic                    w_hit, w_full, w_pass_ok, w_is_admin;
    logic [SLOT_BITS-1:0]    w_hit_slot, w_free_slot;
    logic [I_U_NUM_BITS-1:0] w_perms;
    logic w_stage_name, w_stage_pass, w_commit, w_del, w_sess_set, w_sess_clr;

    // Lowest index wins for both name hits and free slots (loop runs high to low).
    always_comb begin
        w_hit       = 1'b0;
        w_hit_slot  = '0;
        w_full      = 1'b1;
        w_free_slot = '0;
        w_pass_ok   = 1'b0;
        w_perms     = '0;
        for (int i = MAX_USERS - 1; i >= 0; i--) begin
            if (r_occ[i] && r_name[i] == bus.i_a) begin
                w_hit      = 1'b1;
                w_hit_slot = SLOT_BITS'(i);
            end
            if (!r_occ[i]) begin
                w_full      = 1'b0;
                w_free_slot = SLOT_BITS'(i);
            end
            if (r_tgt == SLOT_BITS'(i) && r_pass[i] == bus.i_a) w_pass_ok = 1'b1;
            if (r_logged_in && r_cur_slot == SLOT_BITS'(i)) w_perms = r_perm[i];
        end
    end

    assign w_is_admin = r_logged_in && (r_cur_slot == '0);

`ifdef SHOP_LOCKOUT_EN
    localparam int FW = $clog2(MAX_FAILS + 1);
    logic [FW-1:0] r_fail [MAX_USERS];
    logic          w_locked, w_fail_inc;

    always_comb begin
        w_locked = 1'b0;
        for (int i = 1; i < MAX_USERS; i++) begin
            if (r_occ[i] && r_name[i] == bus.i_a && r_fail[i] == FW'(MAX_FAILS)) w_locked = 1'b1;
        end
    end

    assign w_fail_inc = bus.i_rdy && (r_state == S_PASSWORD) && (r_cmd == C_LOGIN) && !w_pass_ok;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < MAX_USERS; i++) r_fail[i] <= '0;
        end else begin
            for (int i = 0; i < MAX_USERS; i++) begin
                if ((w_sess_set || w_commit) && r_tgt == SLOT_BITS'(i)) begin
                    r_fail[i] <= '0;
                end else if (w_del && w_hit_slot == SLOT_BITS'(i)) begin
                    r_fail[i] <= '0;
                end else if (w_fail_inc && r_tgt == SLOT_BITS'(i) && r_fail[i] != FW'(MAX_FAILS)) begin
                    r_fail[i] <= r_fail[i] + FW'(1);
                end
            end
        end
    end
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_cmd_nxt    = r_cmd;
        w_tgt_nxt    = r_tgt;
        w_msg        = r_msg;
        w_stage_name = 1'b0;
        w_stage_pass = 1'b0;
        w_commit     = 1'b0;
        w_del        = 1'b0;
        w_sess_set   = 1'b0;
        w_sess_clr   = 1'b0;
        if (bus.i_rdy) begin
            case (r_state)
                S_CMD: begin
                    if (bus.i_a == K_LOGIN) begin
                        w_msg       = M_USRNAME;
                        w_cmd_nxt   = C_LOGIN;
                        w_state_nxt = S_USERNAME;
                    end else if (bus.i_a == K_ADDUSR) begin
                        if (!w_is_admin)  w_msg = M_INVPERM;
                        else if (w_full)  w_msg = M_FULL;
                        else begin
                            w_msg       = M_USRNAME;
                            w_cmd_nxt   = C_ADD;
                            w_state_nxt = S_USERNAME;
                        end
                    end else if (bus.i_a == K_DELUSR) begin
                        if (!w_is_admin) w_msg = M_INVPERM;
                        else begin
                            w_msg       = M_USRNAME;
                            w_cmd_nxt   = C_DEL;
                            w_state_nxt = S_USERNAME;
                        end
                    end else if (bus.i_a == K_LOGOUT) begin
                        w_msg      = r_logged_in ? M_LOGOUT : M_NOSESS;
                        w_sess_clr = r_logged_in;
                    end else begin
                        w_msg = M_INVCMD;
                    end
                end
                S_USERNAME: begin
                    w_state_nxt = S_CMD;
                    case (r_cmd)
                        C_LOGIN: begin
                            if (!w_hit) w_msg = M_UNKNOWN;
`ifdef SHOP_LOCKOUT_EN
                            else if (w_locked) w_msg = M_LOCKED;
`endif
                            else begin
                                w_msg       = M_PASSWD;
                                w_tgt_nxt   = w_hit_slot;
                                w_state_nxt = S_PASSWORD;
                            end
                        end
                        C_ADD: begin
                            if (w_hit) w_msg = M_TAKEN;
                            else begin
                                w_msg        = M_PASSWD;
                                w_tgt_nxt    = w_free_slot;
                                w_stage_name = 1'b1;
                                w_state_nxt  = S_PASSWORD;
                            end
                        end
                        default: begin
                            if (!w_hit)                 w_msg = M_UNKNOWN;
                            else if (w_hit_slot == '0)  w_msg = M_NODELADM;
                            else begin
                                w_msg = M_DELETED;
                                w_del = 1'b1;
                            end
                        end
                    endcase
                end
                S_PASSWORD: begin
                    w_state_nxt = S_CMD;
                    if (r_cmd == C_ADD) begin
                        w_msg        = M_PERMS;
                        w_stage_pass = 1'b1;
                        w_state_nxt  = S_PERMS;
                    end else if (w_pass_ok) begin
                        w_msg      = M_LOGGEDIN;
                        w_sess_set = 1'b1;
                    end else begin
                        w_msg = M_BADPASS;
                    end
                end
                default: begin
                    // The new slot only becomes visible here, so an abandoned add leaves no trace.
                    w_msg       = M_ADDED;
                    w_commit    = 1'b1;
                    w_state_nxt = S_CMD;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= S_CMD;
            r_cmd       <= C_LOGIN;
            r_tgt       <= '0;
            r_new_name  <= '0;
            r_new_pass  <= '0;
            r_msg       <= M_CMD;
            r_vld       <= 1'b0;
            r_logged_in <= 1'b0;
            r_cur_slot  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cmd   <= w_cmd_nxt;
            r_tgt   <= w_tgt_nxt;
            r_vld   <= bus.i_rdy;
            if (bus.i_rdy)    r_msg      <= w_msg;
            if (w_stage_name) r_new_name <= bus.i_a;
            if (w_stage_pass) r_new_pass <= bus.i_a;
            if (w_sess_set) begin
                r_logged_in <= 1'b1;
                r_cur_slot  <= r_tgt;
            end else if (w_sess_clr) begin
                r_logged_in <= 1'b0;
                r_cur_slot  <= '0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < MAX_USERS; i++) begin
                r_occ[i]  <= (i == 0);
                r_name[i] <= (i == 0) ? ADMIN_USERNAME : '0;
                r_pass[i] <= (i == 0) ? ADMIN_PASSWORD : '0;
                r_perm[i] <= (i == 0) ? '1 : '0;
            end
        end else begin
            for (int i = 0; i < MAX_USERS; i++) begin
                if (w_commit && r_tgt == SLOT_BITS'(i)) begin
                    r_occ[i]  <= 1'b1;
                    r_name[i] <= r_new_name;
                    r_pass[i] <= r_new_pass;
                    r_perm[i] <= bus.i_u;
                end else if (w_del && w_hit_slot == SLOT_BITS'(i)) begin
                    r_occ[i]  <= 1'b0;
                    r_name[i] <= '0;
                    r_pass[i] <= '0;
                    r_perm[i] <= '0;
                end
            end
        end
    end

    assign bus.o_a     = r_msg;
    assign bus.o_vld   = r_vld;
    assign o_logged_in = r_logged_in;
    assign o_cur_slot  = r_cur_slot;
    assign o_cur_perms = w_perms;
endmodule

// File: tb/tb_shop_user_db.sv
// Directed bench for shop_user_db: token sequences with hand-computed status words.
module tb_shop_user_db;
    logic       clk;
    logic       rst_n;
    logic       logged_in;
    logic [3:0] cur_slot;
    logic [3:0] cur_perms;
    int         checks;
    int         failures;
    logic [55:0] nm;

    shop_user_db_if #(.I_A_NUM_ASCII_CHARS(7), .O_A_NUM_ASCII_CHARS(9), .I_U_NUM_BITS(4)) bus ();

    shop_user_db dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .bus         (bus.slave),
        .o_logged_in (logged_in),
        .o_cur_slot  (cur_slot),
        .o_cur_perms (cur_perms)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Token presented at negedge, sampled at the next posedge, response checked 1 ns later.
    task automatic send(input logic [55:0] tok, input logic [3:0] u, input logic [71:0] exp);
        @(negedge clk);
        bus.i_rdy = 1'b1;
        bus.i_a   = tok;
        bus.i_u   = u;
        @(posedge clk);
        #1;
        bus.i_rdy = 1'b0;
        check("vld", 72'(bus.o_vld), 72'd1);
        check("resp", bus.o_a, exp);
    endtask

    task automatic session(input logic li, input logic [3:0] slot, input logic [3:0] perms);
        check("logged_in", 72'(logged_in), 72'(li));
        check("cur_slot", 72'(cur_slot), 72'(slot));
        check("cur_perms", 72'(cur_perms), 72'(perms));
    endtask

    task automatic login_admin();
        send("Login", 4'h0, "Usrname?");
        send("Adm", 4'h0, "Passwd?");
        send("AdmPass", 4'h0, "LoggedIn");
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_resp", bus.o_a, "Cmd?");
        check("rst_vld", 72'(bus.o_vld), 72'd0);
        session(1'b0, 4'h0, 4'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        bus.i_rdy = 1'b0;
        bus.i_a   = '0;
        bus.i_u   = '0;
        rst_n     = 1'b1;
        #2;
        do_reset();

        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("idle_vld", 72'(bus.o_vld), 72'd0);
            check("idle_resp", bus.o_a, "Cmd?");
        end
        session(1'b0, 4'h0, 4'h0);

        send("Logout", 4'h0, "NoSession");
        send("Foo", 4'h0, "InvalCmd");
        send("AddUsr", 4'h0, "InvalPerm");

        login_admin();
        session(1'b1, 4'h0, 4'hF);

        send("AddUsr", 4'h0, "Usrname?");
        send("bob", 4'h0, "Passwd?");
        send("pw1", 4'h0, "Perms?");
        send("x", 4'h3, "UsrAdded");
        @(posedge clk);
        #1;
        check("vld_drop", 72'(bus.o_vld), 72'd0);
        check("resp_hold", bus.o_a, "UsrAdded");

        send("Logout", 4'h0, "LoggedOut");
        session(1'b0, 4'h0, 4'h0);
        send("Login", 4'h0, "Usrname?");
        send("bob", 4'h0, "Passwd?");
        send("bad", 4'h0, "BadPass");
        session(1'b0, 4'h0, 4'h0);
        send("Login", 4'h0, "Usrname?");
        send("bob", 4'h0, "Passwd?");
        send("pw1", 4'h0, "LoggedIn");
        session(1'b1, 4'h1, 4'h3);
        send("AddUsr", 4'h0, "InvalPerm");
        send("DelUsr", 4'h0, "InvalPerm");
        send("Login", 4'h0, "Usrname?");
        send("bob", 4'h0, "Passwd?");
        send("AdmPass", 4'h0, "BadPass");
        session(1'b1, 4'h1, 4'h3);

        login_admin();
        session(1'b1, 4'h0, 4'hF);
        send("AddUsr", 4'h0, "Usrname?");
        send("bob", 4'h0, "UsrTaken");
        for (int i = 2; i < 8; i++) begin
            nm       = '0;
            nm[15:8] = 8'h75;
            nm[7:0]  = 8'(8'h30 + i);
            send("AddUsr", 4'h0, "Usrname?");
            send(nm, 4'h0, "Passwd?");
            send("p", 4'h0, "Perms?");
            send("x", 4'(i), "UsrAdded");
        end
        send("AddUsr", 4'h0, "UsrsFull");
        send("DelUsr", 4'h0, "Usrname?");
        send("Adm", 4'h0, "NoDelAdmn");
        send("DelUsr", 4'h0, "Usrname?");
        send("bob", 4'h0, "UsrDeletd");
        send("DelUsr", 4'h0, "Usrname?");
        send("bob", 4'h0, "UsrUnknwn");
        send("Login", 4'h0, "Usrname?");
        send("bob", 4'h0, "UsrUnknwn");
        session(1'b1, 4'h0, 4'hF);
        send("Login", 4'h0, "Usrname?");
        send("Logout", 4'h0, "UsrUnknwn");

        send("AddUsr", 4'h0, "Usrname?");
        send("carol", 4'h0, "Passwd?");
        send("cpw", 4'h0, "Perms?");
        send("x", 4'h5, "UsrAdded");
        send("Login", 4'h0, "Usrname?");
        send("carol", 4'h0, "Passwd?");
        send("cpw", 4'h0, "LoggedIn");
        session(1'b1, 4'h1, 4'h5);
        send("Login", 4'h0, "Usrname?");
        send("u5", 4'h0, "Passwd?");
        send("p", 4'h0, "LoggedIn");
        session(1'b1, 4'h5, 4'h5);

        login_admin();
        send("DelUsr", 4'h0, "Usrname?");
        send("u7", 4'h0, "UsrDeletd");
        send("AddUsr", 4'h0, "Usrname?");
        send("dave", 4'h0, "Passwd?");
        @(posedge clk);
        #1;
        do_reset();
        send("Login", 4'h0, "Usrname?");
        send("dave", 4'h0, "UsrUnknwn");
        send("Login", 4'h0, "Usrname?");
        send("carol", 4'h0, "UsrUnknwn");
        login_admin();
        session(1'b1, 4'h0, 4'hF);

`ifdef SHOP_LOCKOUT_EN
        send("AddUsr", 4'h0, "Usrname?");
        send("bob", 4'h0, "Passwd?");
        send("pw1", 4'h0, "Perms?");
        send("x", 4'h3, "UsrAdded");
        for (int i = 0; i < 3; i++) begin
            send("Login", 4'h0, "Usrname?");
            send("bob", 4'h0, "Passwd?");
            send("nope", 4'h0, "BadPass");
        end
        send("Login", 4'h0, "Usrname?");
        send("bob", 4'h0, "UsrLocked");
        for (int i = 0; i < 3; i++) begin
            send("Login", 4'h0, "Usrname?");
            send("Adm", 4'h0, "Passwd?");
            send("nope", 4'h0, "BadPass");
        end
        send("Login", 4'h0, "Usrname?");
        send("Adm", 4'h0, "Passwd?");
        send("AdmPass", 4'h0, "LoggedIn");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
